key_filter_array: RTL and testbench
===================================

// Module: key_filter_array
// PURPOSE
//  Parametrised N-channel key conditioner and successor of the two-key check block. Each raw
//  key is synchronised, debounced and tracked by a per-channel press FSM that emits one-cycle
//  press, release, short-click, long-press and auto-repeat enables. Sits between board keys
//  and the clock control logic (reset/pause/set/adjust keys).
// PARAMETERS
//  N_KEYS           2     number of independent key channels (>=1)
//  ACTIVE_LEVEL     1     raw level meaning "pressed" (1 = active-high keys)
//  DEBOUNCE_CYCLES  20    cycles of consistent new level needed to accept a change (>=2)
//  LONG_CYCLES      1000  cycles held after accepted press before long-press fires (>=2)
//  REPEAT_CYCLES    200   auto-repeat period once in long-press (>=1)
//  REPEAT_EN        1     1 = emit key_rep_en while held past long-press; 0 = never
// PORTS
//  clk           in   1       system clock (1 kHz tick domain)
//  rst           in   1       asynchronous, active-high reset
//  key_in        in   N_KEYS  raw, asynchronous key inputs, bit i = channel i
//  key_level     out  N_KEYS  debounced level, 1 = pressed (polarity-normalised)
//  key_press_en  out  N_KEYS  1-cycle pulse on accepted press
//  key_rel_en    out  N_KEYS  1-cycle pulse on accepted release
//  key_short_en  out  N_KEYS  1-cycle pulse on release before long-press fired
//  key_long_en   out  N_KEYS  1-cycle pulse when hold reaches LONG_CYCLES
//  key_rep_en    out  N_KEYS  1-cycle pulse every REPEAT_CYCLES while held after long-press
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-high. All outputs 0, sync FFs loaded
//    with released level, all counters 0, every FSM in IDLE. Reset mid-press discards the press;
//    a key still held after reset release is re-accepted as a new press (press_en fires once).
//  - Sync: 2-FF synchroniser per channel; s = sync2 XOR ~ACTIVE_LEVEL (1 = pressed).
//  - Debounce: db_cnt ($clog2(DEBOUNCE_CYCLES) bits) clears whenever s == key_level; else
//    increments; when db_cnt == DEBOUNCE_CYCLES-1 and s != key_level, key_level <= s, db_cnt <= 0.
//    Glitch shorter than DEBOUNCE_CYCLES cycles never changes key_level.
//  - Latency: raw edge held steady -> key_level change on the (DEBOUNCE_CYCLES+2)th clk edge.
//  - Pulses are registered and coincide with the key_level edge they report.
//  - FSM per channel: IDLE, HELD, LONG.
//    IDLE: accepted press -> press_en, hold_cnt <= 0, go HELD.
//    HELD: hold_cnt++ each cycle; at hold_cnt == LONG_CYCLES-1 -> long_en, hold_cnt <= 0, go LONG.
//          accepted release -> rel_en + short_en same cycle, go IDLE.
//    LONG: if REPEAT_EN, hold_cnt++; at REPEAT_CYCLES-1 -> rep_en, hold_cnt wraps to 0.
//          accepted release -> rel_en only (no short_en), go IDLE.
//  - Release and long-press threshold in same cycle: release wins (rel_en + short_en, no long_en).
//  - Release and repeat threshold in same cycle: release wins (no rep_en).
//  - hold_cnt width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)); never overflows (always wraps/clears).
//  - Channels fully independent; simultaneous events on different channels all reported.
//  - At most one of press/rel per channel per cycle; short_en only with rel_en.
// TESTING (bench params: N_KEYS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3)
//  1 Reset: rst=1 with key_in=2'b11 -> all outputs 0; rst=0 -> key_level rises edge 6, one press_en.
//  2 Glitch: key_in[0] high 3 cycles then low -> key_level[0] stays 0, no pulses.
//  3 Short click: key_in[0] high 8 cycles -> press_en at edge 6, rel_en+short_en 8 cycles later, no long_en.
//  4 Long+repeat: key_in[1] held 30 cycles -> press_en, long_en 10 cycles later, rep_en every 3, rel_en no short_en.
//  5 REPEAT_EN=0, same hold -> long_en once, zero rep_en, rel_en on release.
//  6 Both keys pressed same cycle, ACTIVE_LEVEL=0 (drive 0) -> press_en=2'b11 same edge; rst mid-hold clears all.

Source files
------------

// File: rtl/key_filter_array.sv
// N-channel key conditioner: 2-FF sync, debounce and per-channel press FSM
// emitting one-cycle press/release/short/long/repeat enables.
module key_filter_array #(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned ACTIVE_LEVEL    = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned LONG_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 200,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press_en,
  output logic [N_KEYS-1:0] key_rel_en,
  output logic [N_KEYS-1:0] key_short_en,
  output logic [N_KEYS-1:0] key_long_en,
  output logic [N_KEYS-1:0] key_rep_en
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);
  localparam logic        REL_LVL  = (ACTIVE_LEVEL != 0) ? 1'b0 : 1'b1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed_c;

  // Synchronisers start at the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {N_KEYS{REL_LVL}};
      sync2_q <= {N_KEYS{REL_LVL}};
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_c = sync2_q ^ {N_KEYS{REL_LVL}};

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_q;
    state_e            state_q;
    logic              level_q;
    logic              press_q;
    logic              rel_q;
    logic              short_q;
    logic              long_q;
    logic              rep_q;
    logic              differ_c;
    logic              db_done_c;
    logic              acc_press_c;
    logic              acc_rel_c;

    assign differ_c    = pressed_c[i] != level_q;
    assign db_done_c   = db_cnt_q == DB_LAST;
    assign acc_press_c = differ_c & db_done_c & pressed_c[i];
    assign acc_rel_c   = differ_c & db_done_c & ~pressed_c[i];

    // Debounce: a new level must persist for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else if (!differ_c) begin
        db_cnt_q <= '0;
      end else if (db_done_c) begin
        db_cnt_q <= '0;
        level_q  <= pressed_c[i];
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end

    // Press FSM acts on the same accept strobe, so pulses line up with the level edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (acc_press_c) begin
              press_q <= 1'b1;
              hold_q  <= '0;
              state_q <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (acc_rel_c) begin
              rel_q   <= 1'b1;
              short_q <= 1'b1;
              hold_q  <= '0;
              state_q <= ST_IDLE;
            end else if (hold_q == LONG_LAST) begin
              long_q  <= 1'b1;
              hold_q  <= '0;
              state_q <= ST_LONG;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          ST_LONG: begin
            if (acc_rel_c) begin
              rel_q   <= 1'b1;
              hold_q  <= '0;
              state_q <= ST_IDLE;
            end else if (REPEAT_EN != 0) begin
              if (hold_q == REP_LAST) begin
                rep_q  <= 1'b1;
                hold_q <= '0;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
          end
          default: begin
            hold_q  <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign key_level[i]    = level_q;
    assign key_press_en[i] = press_q;
    assign key_rel_en[i]   = rel_q;
    assign key_short_en[i] = short_q;
    assign key_long_en[i]  = long_q;
    assign key_rep_en[i]   = rep_q;
  end

endmodule

// File: tb/tb_key_filter_array.sv
// Scoreboard bench for key_filter_array: per-cycle expected outputs are queued
// from the key timing, then popped and compared each cycle.
module tb_key_filter_array;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;
  localparam int unsigned REP  = 3;
  localparam int unsigned TL   = 48;

  typedef struct packed {
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] shrt;
    logic [1:0] lng;
    logic [1:0] rep;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] key_main, key_norep, key_low;

  logic [1:0] lv_m, pr_m, rl_m, sh_m, lg_m, rp_m;
  logic [1:0] lv_n, pr_n, rl_n, sh_n, lg_n, rp_n;
  logic [1:0] lv_l, pr_l, rl_l, sh_l, lg_l, rp_l;
  obs_t obs_main, obs_norep, obs_low;

  int tests  = 0;
  int failed = 0;
  obs_t tl [TL];
  obs_t sb_q [$];

  always #5 clk = ~clk;

  key_filter_array #(.N_KEYS(2), .ACTIVE_LEVEL(1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
                     .REPEAT_CYCLES(REP), .REPEAT_EN(1)) u_main (
    .clk(clk), .rst(rst), .key_in(key_main), .key_level(lv_m), .key_press_en(pr_m),
    .key_rel_en(rl_m), .key_short_en(sh_m), .key_long_en(lg_m), .key_rep_en(rp_m));

  key_filter_array #(.N_KEYS(2), .ACTIVE_LEVEL(1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
                     .REPEAT_CYCLES(REP), .REPEAT_EN(0)) u_norep (
    .clk(clk), .rst(rst), .key_in(key_norep), .key_level(lv_n), .key_press_en(pr_n),
    .key_rel_en(rl_n), .key_short_en(sh_n), .key_long_en(lg_n), .key_rep_en(rp_n));

  key_filter_array #(.N_KEYS(2), .ACTIVE_LEVEL(0), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
                     .REPEAT_CYCLES(REP), .REPEAT_EN(1)) u_low (
    .clk(clk), .rst(rst), .key_in(key_low), .key_level(lv_l), .key_press_en(pr_l),
    .key_rel_en(rl_l), .key_short_en(sh_l), .key_long_en(lg_l), .key_rep_en(rp_l));

  assign obs_main  = {lv_m, pr_m, rl_m, sh_m, lg_m, rp_m};
  assign obs_norep = {lv_n, pr_n, rl_n, sh_n, lg_n, rp_n};
  assign obs_low   = {lv_l, pr_l, rl_l, sh_l, lg_l, rp_l};

  function automatic void tl_clear();
    for (int k = 0; k < int'(TL); k++) tl[k] = '0;
  endfunction

  // Key pressed before edges 1..h: level/press at edge DEB+2, release at edge h+DEB+2.
  function automatic void tl_hold(input int ch, input int h, input bit rep_en);
    int p, r;
    p = int'(DEB) + 2;
    r = h + int'(DEB) + 2;
    for (int k = p; k < r; k++) tl[k].level[ch] = 1'b1;
    tl[p].press[ch] = 1'b1;
    tl[r].rel[ch]   = 1'b1;
    if (r - p <= int'(LONG)) begin
      tl[r].shrt[ch] = 1'b1;
    end else begin
      tl[p + int'(LONG)].lng[ch] = 1'b1;
      if (rep_en)
        for (int k = p + int'(LONG) + int'(REP); k < r; k += int'(REP)) tl[k].rep[ch] = 1'b1;
    end
  endfunction

  function automatic void sb_push(input int n);
    for (int k = 1; k <= n; k++) sb_q.push_back(tl[k]);
  endfunction

  task automatic test_reset();
    obs_t exp;
    rst = 1'b1;
    key_main = 2'b11; key_norep = 2'b00; key_low = 2'b11;
    repeat (2) @(negedge clk);
    tests++; if (obs_main !== obs_t'(0)) begin failed++; $display("FAIL reset_main got %h exp 000", obs_main); end
    tests++; if (obs_norep !== obs_t'(0)) begin failed++; $display("FAIL reset_norep got %h exp 000", obs_norep); end
    tests++; if (obs_low !== obs_t'(0)) begin failed++; $display("FAIL reset_low got %h exp 000", obs_low); end
    tl_clear(); tl_hold(0, 8, 1'b1); tl_hold(1, 8, 1'b1); sb_push(16);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      key_main = (k <= 8) ? 2'b11 : 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_main !== exp) begin failed++; $display("FAIL reset_release cyc %0d got %h exp %h", k, obs_main, exp); end
    end
  endtask

  task automatic test_glitch();
    obs_t exp;
    tl_clear(); sb_push(12);
    for (int k = 1; k <= 12; k++) begin
      key_main = (k <= 3) ? 2'b01 : 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_main !== exp) begin failed++; $display("FAIL glitch cyc %0d got %h exp %h", k, obs_main, exp); end
    end
  endtask

  task automatic test_short_click();
    obs_t exp;
    tl_clear(); tl_hold(0, 8, 1'b1); sb_push(16);
    for (int k = 1; k <= 16; k++) begin
      key_main = (k <= 8) ? 2'b01 : 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_main !== exp) begin failed++; $display("FAIL short_click cyc %0d got %h exp %h", k, obs_main, exp); end
    end
  endtask

  task automatic test_long_repeat();
    obs_t exp;
    tl_clear(); tl_hold(1, 30, 1'b1); sb_push(38);
    for (int k = 1; k <= 38; k++) begin
      key_main = (k <= 30) ? 2'b10 : 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_main !== exp) begin failed++; $display("FAIL long_repeat cyc %0d got %h exp %h", k, obs_main, exp); end
    end
  endtask

  task automatic test_long_no_repeat();
    obs_t exp;
    tl_clear(); tl_hold(1, 30, 1'b0); sb_push(38);
    for (int k = 1; k <= 38; k++) begin
      key_norep = (k <= 30) ? 2'b10 : 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_norep !== exp) begin failed++; $display("FAIL long_no_repeat cyc %0d got %h exp %h", k, obs_norep, exp); end
    end
  endtask

  task automatic test_both_low_reset();
    obs_t exp;
    tl_clear(); tl_hold(0, 40, 1'b1); tl_hold(1, 40, 1'b1); sb_push(18);
    for (int k = 1; k <= 18; k++) begin
      key_low = 2'b00;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_low !== exp) begin failed++; $display("FAIL both_low cyc %0d got %h exp %h", k, obs_low, exp); end
    end
    rst = 1'b1;
    #1;
    tests++;
    if (obs_low !== obs_t'(0)) begin failed++; $display("FAIL mid_hold_reset got %h exp 000", obs_low); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tl_clear(); tl_hold(0, 8, 1'b1); tl_hold(1, 8, 1'b1); sb_push(16);
    for (int k = 1; k <= 16; k++) begin
      key_low = (k <= 8) ? 2'b00 : 2'b11;
      @(posedge clk); @(negedge clk);
      exp = sb_q.pop_front();
      tests++;
      if (obs_low !== exp) begin failed++; $display("FAIL after_reset_repress cyc %0d got %h exp %h", k, obs_low, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_click();
    test_long_repeat();
    test_long_no_repeat();
    test_both_low_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
